symbol_depacker: RTL and testbench
==================================

SYMBOL_DEPACKER -- requirements
Module: symbol_depacker

Interface
REQ-001 SHALL have parameter FRAME_SYMS, default 63: symbols per received frame.
REQ-002 SHALL have parameter PAYLOAD_SYMS, default 60: leading frame symbols packed into bytes; must be a multiple of 4 and no greater than FRAME_SYMS.
REQ-003 SHALL have parameter GAP_TIMEOUT, default 64: idle clocks without in_valid that abort a frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 32: output byte buffer entries; must be a power of 2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-low (0 = reset).
REQ-007 SHALL have port in_valid, input, 1: dibit strobe from the QPSK receiver; no backpressure toward the receiver.
REQ-008 SHALL have port in_data, input, 2: demodulated dibit.
REQ-009 SHALL have port out_data, output, 8: packed byte.
REQ-010 SHALL have port out_valid, output, 1: out_data, out_last and out_err are valid.
REQ-011 SHALL have port out_ready, input, 1: sink accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-012 SHALL have port out_last, output, 1: final byte of a frame.
REQ-013 SHALL have port out_err, output, 1: frame aborted by timeout; qualified by out_last.
REQ-014 SHALL have port overflow, output, 1: sticky flag, FIFO push dropped.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT and TRAIL.
REQ-016 IDLE: SHALL go to COLLECT on in_valid; that dibit is symbol 1 of a new frame.
REQ-017 COLLECT: SHALL shift each dibit into the byte MSB-first, so the first dibit lands in bits [7:6].
REQ-018 COLLECT: SHALL push a byte into the FIFO on every 4th dibit.
REQ-019 COLLECT: SHALL push the byte completing PAYLOAD_SYMS with last=1, err=0, then go to TRAIL.
REQ-020 TRAIL: SHALL discard dibits until the symbol count reaches FRAME_SYMS, then go to IDLE.
REQ-021 SHALL hold an idle counter that clears on every in_valid and increments otherwise, saturating at GAP_TIMEOUT.
REQ-022 On timeout in COLLECT with 1-3 dibits pending, SHALL zero-pad the partial byte LSB side and push it with last=1, err=1.
REQ-023 On timeout in COLLECT with 0 dibits pending, SHALL push marker byte 0x00 with last=1, err=1.
REQ-024 After either COLLECT timeout push (REQ-022, REQ-023), SHALL go to IDLE.
REQ-025 On timeout in TRAIL, SHALL go to IDLE with no push.
REQ-026 On the cycle after any return to IDLE, SHALL have the symbol count, dibit count and shift register at 0.
REQ-027 Latency: the 4th dibit accepted in cycle N SHALL give out_valid=1 in cycle N+1 when the FIFO was empty (registered push, first-word-fall-through read).
REQ-028 SHALL keep out_data, out_last and out_err stable while out_valid=1 and out_ready=0.
REQ-029 Push while full with no pop: SHALL drop the byte, set overflow=1 and leave FIFO contents unchanged.
REQ-030 Push while full with a simultaneous pop: SHALL accept the push; occupancy stays unchanged.
REQ-031 Push and pop on an empty FIFO in the same cycle: SHALL make the pushed byte visible next cycle.
REQ-032 Dropped bytes SHALL not alter FSM progress; a frame continues counting symbols.
REQ-033 overflow SHALL be cleared only by reset.
REQ-034 Pointers SHALL be log2(FIFO_DEPTH) bits wide with an extra wrap bit.
REQ-035 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-036 When rst=0 at a clock edge: FSM SHALL be IDLE, and all counters, the shift register and the FIFO pointers SHALL be 0.
REQ-037 During reset SHALL drive out_valid=0, out_last=0, out_err=0, overflow=0 and out_data=0x00.
REQ-038 Reset mid-frame SHALL discard the partial frame and all buffered bytes; no byte is emitted for it.

Structure
REQ-039 Package sdr_pkg SHALL hold: the FSM state enum; default constants FRAME_SYMS_D=63, PAYLOAD_SYMS_D=60, GAP_TIMEOUT_D=64, FIFO_DEPTH_D=32.
REQ-040 SHALL instantiate one sub-module sync_fifo: 10-bit entries {err,last,data[7:0]}, FWFT, full/empty outputs, same clk/rst.

Verification
REQ-041 Dibits 01,10,11,00 on consecutive in_valid, out_ready=1 -> out_data=0x6C, out_valid one cycle after 4th dibit, out_last=0.
REQ-042 Full 63-symbol frame, dibit k = k mod 4, gaps of 8 clocks -> 15 bytes of 0x1B, only the 15th has out_last=1, out_err=0; symbols 61-63 produce nothing.
REQ-043 Frame stopped after 6 dibits (00,01,10,11,11,11), then 64 idle clocks -> bytes 0x1B then 0xF0 with last=1, err=1; FSM back in IDLE.
REQ-044 out_ready=0 held over 3 full frames (45 pushes) -> 32 bytes buffered, overflow=1; releasing out_ready yields exactly 32 bytes in order.
REQ-045 rst=0 asserted at symbol 30, then a new clean frame -> no stale bytes, 15 correct bytes with one out_last.
REQ-046 out_ready toggled every cycle during a frame -> out_data stable while stalled, 15 bytes delivered without loss or duplication.

Source files
------------

// File: rtl/symbol_depacker_pkg.sv
// Shared types and defaults for the QPSK symbol depacker.
package sdr_pkg;

  // Depacker control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_TRAIL   = 2'd2
  } sdr_state_e;

  localparam int FRAME_SYMS_D   = 63;
  localparam int PAYLOAD_SYMS_D = 60;
  localparam int GAP_TIMEOUT_D  = 64;
  localparam int FIFO_DEPTH_D   = 32;

  // One buffered output byte with its frame markers.
  typedef struct packed {
    logic       err;
    logic       last;
    logic [7:0] data;
  } sdr_entry_t;

  // Left-justify a partially filled shift register; zero pending dibits
  // yields the 0x00 abort marker.
  function automatic logic [7:0] pad_partial(input logic [7:0] sr, input logic [1:0] n);
    logic [7:0] res;
    case (n)
      2'd1:    res = {sr[1:0], 6'b0};
      2'd2:    res = {sr[3:0], 4'b0};
      2'd3:    res = {sr[5:0], 2'b0};
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/symbol_depacker_fifo.sv
// First-word-fall-through byte buffer with wrap-bit pointers.
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot the same cycle, so a push into a full buffer
  // is taken when the head is leaving.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/symbol_depacker.sv
// Packs QPSK dibits MSB-first into bytes, frames them and buffers them
// toward a ready/valid sink.
//
// state   | meaning
// IDLE    | waiting for symbol 1 of a frame
// COLLECT | packing payload dibits, pushing every 4th
// TRAIL   | discarding symbols after the payload up to frame end
module symbol_depacker
  import sdr_pkg::*;
#(
  parameter int FRAME_SYMS   = FRAME_SYMS_D,
  parameter int PAYLOAD_SYMS = PAYLOAD_SYMS_D,
  parameter int GAP_TIMEOUT  = GAP_TIMEOUT_D,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_err,
  output logic       overflow
);

  localparam int SW = $clog2(FRAME_SYMS + 1);
  localparam int IW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [SW-1:0] PAYLOAD_CNT = SW'(PAYLOAD_SYMS);
  localparam logic [SW-1:0] FRAME_CNT   = SW'(FRAME_SYMS);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(GAP_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(GAP_TIMEOUT - 1);

  sdr_state_e    state_q, state_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [1:0]    dib_cnt_q, dib_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          ovf_q, ovf_d;

  logic [SW-1:0] sym_next;
  logic [7:0]    shift_in;
  logic          timeout;
  logic          push;
  sdr_entry_t    push_entry;
  sdr_entry_t    head_entry;
  logic          fifo_full;
  logic          fifo_empty;

  assign sym_next = sym_cnt_q + {{(SW-1){1'b0}}, 1'b1};
  assign shift_in = {shift_q[5:0], in_data};

  // Timeout fires once, on the clock that takes the idle run to its limit.
  assign timeout = !in_valid && (idle_cnt_q == IDLE_LAST);

  // Idle-gap counter: cleared by any dibit, saturating at the limit.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (in_valid)                    idle_cnt_d = '0;
    else if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + {{(IW-1){1'b0}}, 1'b1};
  end

  // Frame FSM: symbol counting, byte assembly and buffer pushes.
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    dib_cnt_d  = dib_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_COLLECT;
          sym_cnt_d = {{(SW-1){1'b0}}, 1'b1};
          dib_cnt_d = 2'd1;
          shift_d   = {6'b0, in_data};
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          sym_cnt_d = sym_next;
          dib_cnt_d = dib_cnt_q + 2'd1;
          shift_d   = shift_in;
          if (dib_cnt_q == 2'd3) begin
            push            = 1'b1;
            push_entry.data = shift_in;
            if (sym_next == PAYLOAD_CNT) begin
              push_entry.last = 1'b1;
              dib_cnt_d       = 2'd0;
              shift_d         = 8'h00;
              if (PAYLOAD_SYMS == FRAME_SYMS) begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
              end else begin
                state_d = ST_TRAIL;
              end
            end
          end
        end else if (timeout) begin
          push            = 1'b1;
          push_entry.err  = 1'b1;
          push_entry.last = 1'b1;
          push_entry.data = pad_partial(shift_q, dib_cnt_q);
          state_d         = ST_IDLE;
          sym_cnt_d       = '0;
          dib_cnt_d       = 2'd0;
          shift_d         = 8'h00;
        end
      end
      ST_TRAIL: begin
        if (in_valid) begin
          sym_cnt_d = sym_next;
          if (sym_next == FRAME_CNT) begin
            state_d   = ST_IDLE;
            sym_cnt_d = '0;
          end
        end else if (timeout) begin
          state_d   = ST_IDLE;
          sym_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sym_cnt_d = '0;
        dib_cnt_d = 2'd0;
        shift_d   = 8'h00;
      end
    endcase
  end

  // A push into a full buffer is lost only when the head is not leaving.
  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !out_ready) ovf_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      dib_cnt_q  <= 2'd0;
      shift_q    <= 8'h00;
      idle_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      dib_cnt_q  <= dib_cnt_d;
      shift_q    <= shift_d;
      idle_cnt_q <= idle_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs are forced quiet while reset is held, before the first edge too.
  assign out_valid = rst & ~fifo_empty;
  assign out_data  = rst ? head_entry.data : 8'h00;
  assign out_last  = rst & head_entry.last;
  assign out_err   = rst & head_entry.err;
  assign overflow  = rst & ovf_q;

endmodule

// File: tb/tb_symbol_depacker.sv
// Randomized self-checking bench for symbol_depacker with a frame-level
// reference model.
module tb_symbol_depacker;

  localparam int FRAME   = 63;
  localparam int PAYLOAD = 60;
  localparam int GAP     = 64;
  localparam int DEPTH   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];

  symbol_depacker #(
    .FRAME_SYMS   (FRAME),
    .PAYLOAD_SYMS (PAYLOAD),
    .GAP_TIMEOUT  (GAP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Record every completed transfer as {err,last,data}.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) rx_q.push_back({out_err, out_last, out_data});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected bytes of one frame from its dibit list.
  task automatic model_frame(input logic [1:0] d[$], input bit timed_out);
    int n;
    int nb;
    int rem;
    logic [7:0] b;
    n  = d.size();
    nb = ((n < PAYLOAD) ? n : PAYLOAD) / 4;
    for (int i = 0; i < nb; i++) begin
      b = {d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]};
      exp_q.push_back({1'b0, (4*i+4 == PAYLOAD), b});
    end
    if (timed_out && n < PAYLOAD) begin
      rem = n % 4;
      b = 8'h00;
      for (int j = 0; j < rem; j++) b[7-2*j -: 2] = d[4*nb+j];
      exp_q.push_back({2'b11, b});
    end
  endtask

  // Drive n dibits with random gaps; short frames are left to time out.
  task automatic drive_frame(input int n, input int gmin, input int gmax, input bit kpat);
    logic [1:0] d[$];
    for (int k = 0; k < n; k++) d.push_back(kpat ? 2'(k % 4) : 2'($urandom_range(0, 3)));
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = d[k];
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat ($urandom_range(gmin, gmax)) begin @(posedge clk); #1; end
    end
    model_frame(d, n < FRAME);
    if (n < FRAME) repeat (GAP + 4) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rx(input int want, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < want && c < budget) begin @(posedge clk); #1; c++; end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b want 0", out_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL post_rst_overflow got %b want 0", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b00;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = seq[k];
      @(posedge clk); #1;
    end
    in_data = seq[3];
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h6C) begin errors++; $display("FAIL basic_data got %h want 6c", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL basic_last got %b want 0", out_last); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    drive_frame(FRAME, 8, 8, 1'b1);
    wait_rx(exp_q.size(), 500);
    checks++; if (rx_q.size() !== 15) begin errors++; $display("FAIL full_frame_count got %0d want 15", rx_q.size()); end
    for (int i = 0; i < 15 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== {1'b0, (i == 14), 8'h1B}) begin
        errors++; $display("FAIL full_frame_byte%0d got %h want %h", i, rx_q[i], {1'b0, (i == 14), 8'h1B});
      end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] seq [6];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11; seq[4] = 2'b11; seq[5] = 2'b11;
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = seq[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (63) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", out_valid); end
    checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL timeout_first_count got %0d want 1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 10'h01B) begin errors++; $display("FAIL timeout_first_byte got %h want 01b", rx_q[0]); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL timeout_valid got %b want 1", out_valid); end
    checks++; if ({out_err, out_last, out_data} !== 10'h3F0) begin
      errors++; $display("FAIL timeout_byte got %h want 3f0", {out_err, out_last, out_data});
    end
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    rx_q.delete(); exp_q.delete();
    drive_frame(FRAME, 0, 2, 1'b0);
    wait_rx(exp_q.size(), 500);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL after_timeout_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL after_timeout_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    drive_frame(FRAME, 0, 3, 1'b0);
    drive_frame(FRAME, 0, 3, 1'b0);
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
    @(posedge clk); #1;
    drive_frame(FRAME, 0, 3, 1'b0);
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    @(posedge clk); #1;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    out_ready = 1'b1;
    wait_rx(DEPTH, 300);
    checks++; if (rx_q.size() !== DEPTH) begin errors++; $display("FAIL ovf_drain_count got %0d want %0d", rx_q.size(), DEPTH); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    rx_q.delete(); exp_q.delete();
    drive_frame(FRAME, 0, 3, 1'b0);
    wait_rx(exp_q.size(), 500);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_next_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_next_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int lasts;
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1; in_data = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf_before got %b want 1", overflow); end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_cleared got %b want 0", overflow); end
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL mid_stale_bytes got %0d want 0", rx_q.size()); end
    rx_q.delete();
    drive_frame(FRAME, 0, 4, 1'b0);
    wait_rx(exp_q.size(), 500);
    checks++; if (rx_q.size() !== 15) begin errors++; $display("FAIL mid_count got %0d want 15", rx_q.size()); end
    lasts = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      if (rx_q[i][8]) lasts++;
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (lasts !== 1) begin errors++; $display("FAIL mid_last_count got %0d want 1", lasts); end
  endtask

  task automatic test_ready_toggle();
    bit done;
    done = 1'b0;
    rx_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    fork
      begin
        drive_frame(FRAME, 0, 0, 1'b0);
        done = 1'b1;
      end
      begin
        logic [9:0] held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        while (!done) begin
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (!out_valid || {out_err, out_last, out_data} !== held) begin
              errors++; $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, {out_err, out_last, out_data}, held);
            end
          end
          stalled = out_valid && !out_ready;
          held = {out_err, out_last, out_data};
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_rx(exp_q.size(), 300);
    checks++; if (rx_q.size() !== 15) begin errors++; $display("FAIL toggle_count got %0d want 15", rx_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    rx_q.delete(); exp_q.delete();
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          if ($urandom_range(0, 2) == 0) drive_frame($urandom_range(1, FRAME - 1), 0, 6, 1'b0);
          else                           drive_frame(FRAME, 0, 6, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_rx(exp_q.size(), 500);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL random_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    do_reset();
    test_full_frame();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_ready_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
